// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port integer register file: read ports, two write
// ports, scoreboard set and ready.
interface regfile_mp_if #(
   parameter int XLEN = 64,
   parameter int AW   = 5,
   parameter int NRD  = 2
);
   logic                ready;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                wa_en;
   logic [AW-1:0]       wa_addr;
   logic [XLEN-1:0]     wa_data;
   logic                wb_en;
   logic [AW-1:0]       wb_addr;
   logic [XLEN-1:0]     wb_data;
   logic                sb_set_en;
   logic [AW-1:0]       sb_set_addr;

   modport master (
      input  ready, rd_data, rd_busy,
      output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
             sb_set_en, sb_set_addr
   );

   modport slave (
      output ready, rd_data, rd_busy,
      input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
             sb_set_en, sb_set_addr
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with two posedge write ports, combinational
// read ports with optional write bypass, a pending scoreboard and a clear sweep.
//
// state | meaning
// CLEAR | sweeping regs[1..NREGS-1] to zero; writes/sets ignored, reads return 0
// RUN   | normal operation until the next reset
module regfile_mp #(
   parameter int XLEN   = 64,
   parameter int NREGS  = 32,
   parameter int AW     = 5,
   parameter int NRD    = 2,
   parameter int BYPASS = 1
) (
   input logic        clk,
   input logic        rst_n,
   regfile_mp_if.slave bus
);
   typedef enum logic {CLEAR, RUN} state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   state_t              state;
   logic [AW-1:0]       clr_idx;
   logic                ready_q;
   logic [XLEN-1:0]     regs [NREGS];
   logic [NREGS-1:0]    pend;

   logic [NRD*XLEN-1:0] rd_data_c;
   logic [NRD-1:0]      rd_busy_c;
   logic [AW-1:0]       ra;
   logic [XLEN-1:0]     rd;
   logic                rbusy;
   logic                hit_a;
   logic                hit_b;
   logic                hit_s;

   // x0 is never written; its storage slot is simply masked on read
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= CLEAR;
         clr_idx <= AW'(1);
         ready_q <= 1'b0;
         pend    <= '0;
      end else begin
         case (state)
            CLEAR: begin
               regs[clr_idx] <= '0;
               clr_idx       <= clr_idx + AW'(1);
               if (clr_idx == LAST_IDX) begin
                  state   <= RUN;
                  ready_q <= 1'b1;
               end
            end
            RUN: begin
               // port B is written last so it wins an address collision
               if (bus.wa_en && bus.wa_addr != '0) begin
                  regs[bus.wa_addr] <= bus.wa_data;
                  pend[bus.wa_addr] <= 1'b0;
               end
               if (bus.wb_en && bus.wb_addr != '0) begin
                  regs[bus.wb_addr] <= bus.wb_data;
                  pend[bus.wb_addr] <= 1'b0;
               end
               if (bus.sb_set_en && bus.sb_set_addr != '0) begin
                  pend[bus.sb_set_addr] <= 1'b1;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      ra        = '0;
      rd        = '0;
      rbusy     = 1'b0;
      hit_a     = 1'b0;
      hit_b     = 1'b0;
      hit_s     = 1'b0;
      for (int k = 0; k < NRD; k++) begin
         ra    = bus.rd_addr[k*AW +: AW];
         hit_a = bus.wa_en && (bus.wa_addr == ra);
         hit_b = bus.wb_en && (bus.wb_addr == ra);
         hit_s = bus.sb_set_en && (bus.sb_set_addr == ra);
         rd    = '0;
         rbusy = 1'b0;
         if (state == RUN && ra != '0) begin
            rd    = regs[ra];
            rbusy = pend[ra];
            if (BYPASS != 0) begin
               if (hit_b) begin
                  rd = bus.wb_data;
               end else if (hit_a) begin
                  rd = bus.wa_data;
               end
               // a same-cycle set re-arms the entry, so busy must not drop
               if ((hit_a || hit_b) && !hit_s) begin
                  rbusy = 1'b0;
               end
            end
         end
         rd_data_c[k*XLEN +: XLEN] = rd;
         rd_busy_c[k]              = rbusy;
      end
   end

   assign bus.ready   = ready_q;
   assign bus.rd_data = rd_data_c;
   assign bus.rd_busy = rd_busy_c;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypass and stored-read variants driven in
// lockstep, plus a small 16x32 three-port instance.
module tb_regfile_mp;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   regfile_mp_if #(.XLEN(64), .AW(5), .NRD(2)) if0 ();
   regfile_mp_if #(.XLEN(64), .AW(5), .NRD(2)) if1 ();
   regfile_mp_if #(.XLEN(32), .AW(4), .NRD(3)) if2 ();

   regfile_mp #(.XLEN(64), .NREGS(32), .AW(5), .NRD(2), .BYPASS(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(if0.slave));
   regfile_mp #(.XLEN(64), .NREGS(32), .AW(5), .NRD(2), .BYPASS(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(if1.slave));
   regfile_mp #(.XLEN(32), .NREGS(16), .AW(4), .NRD(3), .BYPASS(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .bus(if2.slave));

   assign if1.rd_addr     = if0.rd_addr;
   assign if1.wa_en       = if0.wa_en;
   assign if1.wa_addr     = if0.wa_addr;
   assign if1.wa_data     = if0.wa_data;
   assign if1.wb_en       = if0.wb_en;
   assign if1.wb_addr     = if0.wb_addr;
   assign if1.wb_data     = if0.wb_data;
   assign if1.sb_set_en   = if0.sb_set_en;
   assign if1.sb_set_addr = if0.sb_set_addr;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic quiet0();
      if0.wa_en = 1'b0; if0.wa_addr = '0; if0.wa_data = '0;
      if0.wb_en = 1'b0; if0.wb_addr = '0; if0.wb_data = '0;
      if0.sb_set_en = 1'b0; if0.sb_set_addr = '0;
   endtask

   task automatic quiet2();
      if2.wa_en = 1'b0; if2.wa_addr = '0; if2.wa_data = '0;
      if2.wb_en = 1'b0; if2.wb_addr = '0; if2.wb_data = '0;
      if2.sb_set_en = 1'b0; if2.sb_set_addr = '0;
   endtask

   // called at a negedge right after rst_n rises; counts posedges to ready
   task automatic wait_ready(input string tag);
      int ra = 0;
      int rc = 0;
      for (int n = 1; n <= 60 && ra == 0; n++) begin
         @(posedge clk); #1;
         if (n == 1) begin
            chk({tag, "_clr_rd"}, if0.rd_data[63:0], 64'd0);
            chk({tag, "_clr_busy"}, {63'd0, if0.rd_busy[0]}, 64'd0);
         end
         if (rc == 0 && if2.ready) rc = n;
         if (ra == 0 && if0.ready) begin
            ra = n;
            quiet0();
         end
      end
      chk({tag, "_ready_a"}, 64'(ra), 64'd31);
      chk({tag, "_ready_c"}, 64'(rc), 64'd15);
      quiet0();
   endtask

   initial begin
      rst_n = 1'b0;
      quiet0();
      quiet2();
      if0.rd_addr = {5'd0, 5'd5};
      if2.rd_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {63'd0, if0.ready}, 64'd0);

      // junk traffic during the sweep must leave no trace
      @(negedge clk);
      rst_n = 1'b1;
      if0.wa_en = 1'b1; if0.wa_addr = 5'd5; if0.wa_data = 64'h1234;
      if0.wb_en = 1'b1; if0.wb_addr = 5'd6; if0.wb_data = 64'h5678;
      if0.sb_set_en = 1'b1; if0.sb_set_addr = 5'd9;
      wait_ready("init");

      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         if0.rd_addr = {5'(i), 5'(i)};
         #1;
         chk($sformatf("zero_a0_x%0d", i), if0.rd_data[63:0], 64'd0);
         chk($sformatf("zero_a1_x%0d", i), if0.rd_data[127:64], 64'd0);
         chk($sformatf("zero_b0_x%0d", i), if1.rd_data[63:0], 64'd0);
         chk($sformatf("idle_busy_x%0d", i), {63'd0, if0.rd_busy[0]}, 64'd0);
      end

      // reset again, then abort the sweep after 10 cycles
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("mid_ready", {63'd0, if0.ready}, 64'd0);
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      wait_ready("mid");

      // write/read with and without bypass
      @(negedge clk);
      if0.rd_addr = {5'd0, 5'd5};
      if0.wa_en = 1'b1; if0.wa_addr = 5'd5; if0.wa_data = 64'hDEAD_BEEF;
      #1;
      chk("wr_byp_a", if0.rd_data[63:0], 64'hDEAD_BEEF);
      chk("wr_nobyp_b", if1.rd_data[63:0], 64'd0);
      @(negedge clk); quiet0(); #1;
      chk("wr_next_a", if0.rd_data[63:0], 64'hDEAD_BEEF);
      chk("wr_next_b", if1.rd_data[63:0], 64'hDEAD_BEEF);

      // collision on x7 and write to x0
      @(negedge clk);
      if0.rd_addr = {5'd7, 5'd7};
      if0.wa_en = 1'b1; if0.wa_addr = 5'd7; if0.wa_data = 64'd1;
      if0.wb_en = 1'b1; if0.wb_addr = 5'd7; if0.wb_data = 64'd2;
      #1;
      chk("conf_byp_a", if0.rd_data[63:0], 64'd2);
      chk("conf_byp_b", if1.rd_data[63:0], 64'd0);
      @(negedge clk);
      quiet0();
      if0.rd_addr = {5'd0, 5'd5};
      if0.wa_en = 1'b1; if0.wa_addr = 5'd0; if0.wa_data = 64'hFFFF;
      #1;
      chk("x0_byp_a", if0.rd_data[127:64], 64'd0);
      @(negedge clk);
      quiet0();
      if0.rd_addr = {5'd7, 5'd0};
      #1;
      chk("x0_next_a", if0.rd_data[63:0], 64'd0);
      chk("x0_next_b", if1.rd_data[63:0], 64'd0);
      chk("conf_next_a", if0.rd_data[127:64], 64'd2);
      chk("conf_next_b", if1.rd_data[127:64], 64'd2);

      // scoreboard on x9
      @(negedge clk);
      if0.rd_addr = {5'd0, 5'd9};
      if0.sb_set_en = 1'b1; if0.sb_set_addr = 5'd9;
      #1;
      chk("sb_set_now", {63'd0, if0.rd_busy[0]}, 64'd0);
      @(negedge clk); quiet0(); #1;
      chk("sb_set_a", {63'd0, if0.rd_busy[0]}, 64'd1);
      chk("sb_set_b", {63'd0, if1.rd_busy[0]}, 64'd1);
      @(negedge clk);
      if0.wb_en = 1'b1; if0.wb_addr = 5'd9; if0.wb_data = 64'd3;
      #1;
      chk("sb_wr_busy_a", {63'd0, if0.rd_busy[0]}, 64'd0);
      chk("sb_wr_data_a", if0.rd_data[63:0], 64'd3);
      chk("sb_wr_busy_b", {63'd0, if1.rd_busy[0]}, 64'd1);
      @(negedge clk); quiet0(); #1;
      chk("sb_clr_a", {63'd0, if0.rd_busy[0]}, 64'd0);
      chk("sb_clr_b", {63'd0, if1.rd_busy[0]}, 64'd0);
      chk("sb_data_b", if1.rd_data[63:0], 64'd3);
      @(negedge clk);
      if0.sb_set_en = 1'b1; if0.sb_set_addr = 5'd9;
      if0.wa_en = 1'b1; if0.wa_addr = 5'd9; if0.wa_data = 64'd4;
      #1;
      chk("sb_both_now_a", {63'd0, if0.rd_busy[0]}, 64'd0);
      chk("sb_both_data_a", if0.rd_data[63:0], 64'd4);
      @(negedge clk); quiet0(); #1;
      chk("sb_both_a", {63'd0, if0.rd_busy[0]}, 64'd1);
      chk("sb_both_b", {63'd0, if1.rd_busy[0]}, 64'd1);
      chk("sb_both_data_b", if1.rd_data[63:0], 64'd4);
      @(negedge clk);
      if0.sb_set_en = 1'b1; if0.sb_set_addr = 5'd9;
      if0.wb_en = 1'b1; if0.wb_addr = 5'd9; if0.wb_data = 64'd5;
      #1;
      chk("sb_hold_now_a", {63'd0, if0.rd_busy[0]}, 64'd1);
      @(negedge clk);
      quiet0();
      if0.wa_en = 1'b1; if0.wa_addr = 5'd9; if0.wa_data = 64'd6;
      #1;
      chk("sb_rel_now_a", {63'd0, if0.rd_busy[0]}, 64'd0);
      chk("sb_rel_now_b", {63'd0, if1.rd_busy[0]}, 64'd1);
      chk("sb_rel_old_b", if1.rd_data[63:0], 64'd5);
      @(negedge clk);
      quiet0();
      if0.rd_addr = {5'd0, 5'd9};
      if0.sb_set_en = 1'b1; if0.sb_set_addr = 5'd0;
      @(negedge clk); quiet0(); #1;
      chk("sb_x0_busy", {63'd0, if0.rd_busy[1]}, 64'd0);
      chk("sb_rel_b", {63'd0, if1.rd_busy[0]}, 64'd0);
      chk("sb_rel_data_b", if1.rd_data[63:0], 64'd6);

      // 16 x 32 bit, three read ports
      @(negedge clk);
      if2.rd_addr = {4'd3, 4'd2, 4'd1};
      if2.wa_en = 1'b1; if2.wa_addr = 4'd1; if2.wa_data = 32'd11;
      if2.wb_en = 1'b1; if2.wb_addr = 4'd2; if2.wb_data = 32'd22;
      #1;
      chk("c_p0_byp", 64'(if2.rd_data[31:0]), 64'd11);
      chk("c_p1_byp", 64'(if2.rd_data[63:32]), 64'd22);
      chk("c_p2_zero", 64'(if2.rd_data[95:64]), 64'd0);
      @(negedge clk);
      quiet2();
      if2.wa_en = 1'b1; if2.wa_addr = 4'd3; if2.wa_data = 32'd33;
      if2.sb_set_en = 1'b1; if2.sb_set_addr = 4'd2;
      #1;
      chk("c_p2_byp", 64'(if2.rd_data[95:64]), 64'd33);
      @(negedge clk); quiet2(); #1;
      chk("c_p0", 64'(if2.rd_data[31:0]), 64'd11);
      chk("c_p1", 64'(if2.rd_data[63:32]), 64'd22);
      chk("c_p2", 64'(if2.rd_data[95:64]), 64'd33);
      chk("c_busy", 64'(if2.rd_busy), 64'd2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
